// File: rtl/sort_pkg.sv
// sort_pkg: shared definitions for the 8-entry bubble-sort controller.
//   DEPTH / WIDTH / AW : array geometry (8 entries of 8 bits, 3-bit address)
//   state_t            : sequencing states of sort_ctrl
package sort_pkg;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP,
        WR_A,
        WR_B,
        DONE
    } state_t;
endpackage

// File: rtl/sort_mem.sv
// sort_mem: 8x8 storage array, one synchronous write port and one
// synchronous (registered) read port.
//   clk, nrst        : clock, asynchronous active-low reset (read register only)
//   rd, rdaddr       : read enable / address; rdata valid the following cycle
//   wr, wraddr, wdata: write enable / address / data
//   rdata            : registered read data
// The array itself is never reset so partially sorted contents survive nrst.
module sort_mem
    import sort_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             rd,
    input  logic             wr,
    input  logic [AW-1:0]    rdaddr,
    input  logic [AW-1:0]    wraddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wraddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= mem[rdaddr];
        end
    end
endmodule

// File: rtl/sort_ctrl.sv
// sort_ctrl: host-accessible 8x8 array with an in-place ascending bubble sort.
//   clk, nrst : clock, asynchronous active-low reset
//   start     : begin sorting (sampled only while ready=1)
//   wr, addr, data_in : host write port (honoured only while ready=1)
//   data_out  : mem[addr], one cycle after addr is presented (idle only)
//   ready     : 1 while idle
//   done      : one-cycle pulse, rises together with ready at the end of a sort
module sort_ctrl
    import sort_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             wr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic             done
);
    state_t           state_reg;
    logic [AW-1:0]    i_reg;
    logic [AW-1:0]    j_reg;
    logic             swapped_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             ready_reg;
    logic             done_reg;

    logic             mem_rd;
    logic             mem_wr;
    logic [AW-1:0]    mem_rdaddr;
    logic [AW-1:0]    mem_wraddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    logic [AW-1:0]    j_inc;
    logic             pass_end;
    logic             swapped_now;
    logic             advance;

    assign j_inc    = j_reg + 3'd1;
    // Pass i compares pairs j = 0 .. 6-i, so j+1 never exceeds 7.
    assign pass_end = (j_reg == (3'd6 - i_reg));
    // The swap flag written in WR_B is not yet visible, so fold it in here.
    assign swapped_now = swapped_reg | (state_reg == WR_B);
    // Strict '>' keeps equal neighbours in place.
    assign advance  = ((state_reg == CMP) && !(a_reg > mem_rdata)) ||
                      (state_reg == WR_B);

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_rdaddr = addr;
        mem_wraddr = addr;
        mem_wdata  = data_in;
        case (state_reg)
            IDLE: begin
                mem_rd = 1'b1;
                mem_wr = wr;
            end
            RD_A: begin
                mem_rd     = 1'b1;
                mem_rdaddr = j_reg;
            end
            RD_B: begin
                mem_rd     = 1'b1;
                mem_rdaddr = j_inc;
            end
            WR_A: begin
                mem_wr     = 1'b1;
                mem_wraddr = j_reg;
                mem_wdata  = b_reg;
            end
            WR_B: begin
                mem_wr     = 1'b1;
                mem_wraddr = j_inc;
                mem_wdata  = a_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            swapped_reg <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= RD_A;
                        ready_reg   <= 1'b0;
                        i_reg       <= '0;
                        j_reg       <= '0;
                        swapped_reg <= 1'b0;
                    end
                end
                RD_A: state_reg <= RD_B;
                RD_B: begin
                    a_reg     <= mem_rdata;
                    state_reg <= CMP;
                end
                CMP: begin
                    b_reg <= mem_rdata;
                    if (a_reg > mem_rdata) begin
                        state_reg <= WR_A;
                    end
                end
                WR_A: state_reg <= WR_B;
                WR_B: swapped_reg <= 1'b1;
                DONE: begin
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase

            // Shared by a non-swapping CMP and the end of a swap (WR_B);
            // these later assignments override the ones above.
            if (advance) begin
                if (!pass_end) begin
                    j_reg     <= j_inc;
                    state_reg <= RD_A;
                end else if (!swapped_now || (i_reg == 3'd6)) begin
                    state_reg <= DONE;
                end else begin
                    i_reg       <= i_reg + 3'd1;
                    j_reg       <= '0;
                    swapped_reg <= 1'b0;
                    state_reg   <= RD_A;
                end
            end
        end
    end

    sort_mem u_mem (
        .clk    (clk),
        .nrst   (nrst),
        .rd     (mem_rd),
        .wr     (mem_wr),
        .rdaddr (mem_rdaddr),
        .wraddr (mem_wraddr),
        .wdata  (mem_wdata),
        .rdata  (mem_rdata)
    );

    assign data_out = mem_rdata;
    assign ready    = ready_reg;
    assign done     = done_reg;
endmodule

// File: tb/tb_sort_ctrl.sv
// tb_sort_ctrl: directed bench for sort_ctrl with a host-level reference
// model (array contents, bubble-sort cost, ready/done timing) checked every
// cycle, plus literal expectations for sort results and cycle counts.
module tb_sort_ctrl;
    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       start = 1'b0;
    logic       wr = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       ready;
    logic       done;

    sort_ctrl dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_pulses = 0;
    int start_edge = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mem [8];
    int m_sorted [8];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_rvalid = 1'b1;
    bit m_unknown = 1'b1;   // array contents not known to the model
    int m_rdata = 0;
    int m_end_edge = 0;
    int edge_cnt = 0;

    // Sorts m_mem into m_sorted, returns cycles from the start edge to done.
    function automatic int model_sort();
        int a [8];
        int cost;
        int t;
        bit sw;
        cost = 0;
        for (int k = 0; k < 8; k++) a[k] = m_mem[k];
        for (int p = 0; p < 7; p++) begin
            sw = 1'b0;
            for (int q = 0; q < 7 - p; q++) begin
                if (a[q] > a[q+1]) begin
                    t = a[q]; a[q] = a[q+1]; a[q+1] = t;
                    cost += 5;
                    sw = 1'b1;
                end else begin
                    cost += 3;
                end
            end
            if (!sw) break;
        end
        for (int k = 0; k < 8; k++) m_sorted[k] = a[k];
        return cost + 1;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            if (m_busy) m_unknown = 1'b1;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_rdata  = 0;
            m_rvalid = 1'b1;
        end else begin
            edge_cnt++;
            m_done = 1'b0;
            if (m_busy) begin
                if (edge_cnt == m_end_edge) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_rvalid = 1'b0;
                    for (int k = 0; k < 8; k++) m_mem[k] = m_sorted[k];
                end
            end else begin
                m_rdata  = m_mem[addr];
                m_rvalid = 1'b1;
                if (wr) m_mem[addr] = int'(data_in);
                if (start) begin
                    m_end_edge = edge_cnt + model_sort();
                    m_busy     = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (nrst) begin
            check("ready", int'(ready), int'(!m_busy));
            check("done", int'(done), int'(m_done));
            if (!m_busy && m_rvalid && !m_unknown)
                check("data_out", int'(data_out), m_rdata);
            if (done) done_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic host_write(input int a, input int d, input bit with_start);
        wr      = 1'b1;
        addr    = a[2:0];
        data_in = d[7:0];
        start   = with_start;
        if (with_start) start_edge = edge_cnt + 1;
        @(negedge clk);
        wr    = 1'b0;
        start = 1'b0;
    endtask

    task automatic load8(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int v6, input int v7,
                         input bit st);
        int v [8];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        v[4] = v4; v[5] = v5; v[6] = v6; v[7] = v7;
        for (int k = 0; k < 8; k++) host_write(k, v[k], st && (k == 7));
    endtask

    task automatic rb8(input string name, input int e0, input int e1, input int e2,
                       input int e3, input int e4, input int e5, input int e6,
                       input int e7);
        int e [8];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        e[4] = e4; e[5] = e5; e[6] = e6; e[7] = e7;
        for (int k = 0; k < 8; k++) begin
            addr = 3'(k);
            @(negedge clk);
            check($sformatf("%s[%0d]", name, k), int'(data_out), e[k]);
        end
    endtask

    task automatic start_sort();
        start      = 1'b1;
        start_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // exp_edges <= 0 leaves the latency to the per-cycle model only.
    task automatic wait_done(input string name, input int exp_edges);
        for (int k = 0; k < 400; k++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            $display("[TB] %s: done after %0d cycles", name, edge_cnt - start_edge);
            if (exp_edges > 0)
                check({name, "_cycles"}, edge_cnt - start_edge, exp_edges);
        end
        @(negedge clk);
    endtask

    task automatic settle_model();
        @(negedge clk);
        m_unknown = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int p0;
        #2 nrst = 1'b0;
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_data_out", int'(data_out), 0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Already ascending: one pass, no swaps.
        load8(0, 1, 2, 3, 4, 5, 6, 7, 1'b0);
        settle_model();
        start_sort();
        wait_done("ascending", 22);
        rb8("asc_rb", 0, 1, 2, 3, 4, 5, 6, 7);

        // Fully reversed: every compare swaps.
        load8(7, 6, 5, 4, 3, 2, 1, 0, 1'b0);
        start_sort();
        wait_done("reversed", 141);
        rb8("rev_rb", 0, 1, 2, 3, 4, 5, 6, 7);

        // Duplicates and extremes; start issued with the last write.
        load8(5, 200, 5, 0, 255, 17, 17, 1, 1'b1);
        wait_done("mixed", 0);
        rb8("mix_rb", 0, 1, 5, 5, 17, 17, 200, 255);

        // Host write and start during a sort are dropped.
        load8(3, 1, 4, 1, 5, 9, 2, 6, 1'b0);
        p0 = done_pulses;
        start_sort();
        repeat (5) @(negedge clk);
        wr = 1'b1; addr = 3'd0; data_in = 8'd99; start = 1'b1;
        @(negedge clk);
        wr = 1'b0; start = 1'b0;
        wait_done("busy_ignore", 0);
        repeat (5) @(negedge clk);
        check("busy_done_pulses", done_pulses - p0, 1);
        rb8("ign_rb", 1, 1, 2, 3, 4, 5, 6, 9);

        // Reset ten cycles into a reversed sort, then sort again.
        load8(7, 6, 5, 4, 3, 2, 1, 0, 1'b0);
        start_sort();
        repeat (10) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_done", int'(done), 0);
        check("midrst_data_out", int'(data_out), 0);
        @(negedge clk);
        nrst = 1'b1;
        rb8("partial_rb", 6, 5, 7, 4, 3, 2, 1, 0);
        m_mem[0] = 6; m_mem[1] = 5; m_mem[2] = 7; m_mem[3] = 4;
        m_mem[4] = 3; m_mem[5] = 2; m_mem[6] = 1; m_mem[7] = 0;
        settle_model();
        start_sort();
        wait_done("restart", 137);
        rb8("restart_rb", 0, 1, 2, 3, 4, 5, 6, 7);

        // Write then immediately read the same address.
        host_write(3, 171, 1'b0);
        @(negedge clk);
        check("wr_then_rd_a3", int'(data_out), 171);
        host_write(6, 42, 1'b0);
        @(negedge clk);
        check("wr_then_rd_a6", int'(data_out), 42);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
